// File: rtl/vip_pkg.sv
// Shared video-pipeline definitions: window-controller FSM encoding and pipeline constants.
// No logic; pure types, constants and a small counter helper.
package vip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } win_state_t;

  localparam int PIPE_LAT    = 2;
  localparam int PRIME_LINES = 2;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/win3x3_shift.sv
// 3x3 pixel window; each row shifts one column (px3 -> px2 -> px1) when en is high.
// One-cycle update, holds contents while en is low; no backpressure.
module win3x3_shift (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] col_top,
  input  logic [7:0] col_mid,
  input  logic [7:0] col_bot,
  output logic [7:0] p11,
  output logic [7:0] p12,
  output logic [7:0] p13,
  output logic [7:0] p21,
  output logic [7:0] p22,
  output logic [7:0] p23,
  output logic [7:0] p31,
  output logic [7:0] p32,
  output logic [7:0] p33
);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else if (en) begin
      p11 <= p12; p12 <= p13; p13 <= col_top;
      p21 <= p22; p22 <= p23; p23 <= col_mid;
      p31 <= p32; p32 <= p33; p33 <= col_bot;
    end
  end

endmodule

// File: rtl/line_win_ctrl.sv
// 3x3 window controller around an external two-tap line shift RAM; frame/line tracking FSM.
// Window and post_* outputs lag the pixel source by 2 cycles; no backpressure (source-timed).
module line_win_ctrl
  import vip_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_y,
  output logic        lb_clken,
  output logic        lb_href,
  output logic [7:0]  lb_shiftin,
  input  logic [7:0]  lb_taps0x,
  input  logic [7:0]  lb_taps1x,
  output logic [7:0]  matrix_p11,
  output logic [7:0]  matrix_p12,
  output logic [7:0]  matrix_p13,
  output logic [7:0]  matrix_p21,
  output logic [7:0]  matrix_p22,
  output logic [7:0]  matrix_p23,
  output logic [7:0]  matrix_p31,
  output logic [7:0]  matrix_p32,
  output logic [7:0]  matrix_p33,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        win_valid,
  output logic        border,
  output logic [9:0]  col_cnt,
  output logic [10:0] row_cnt,
  output logic        err_len
);

  localparam logic [9:0]  COL_LEN  = 10'(IMG_W);
  localparam logic [9:0]  COL_LAST = 10'(IMG_W - 1);
  localparam logic [10:0] ROW_MAX  = 11'(IMG_H);

  win_state_t state;
  logic vsync_d, href_d, vs_armed;
  logic vs_rise, vs_fall, href_rise, href_fall;
  logic [7:0] pix_d1;
  logic [PIPE_LAT-1:0] vs_pipe, href_pipe, clken_pipe;
  logic run_pix, col_edge, row_edge;
  logic [9:0] ctr_col;

  assign lb_clken   = per_frame_clken;
  assign lb_href    = per_frame_href;
  assign lb_shiftin = per_img_y;

  // vs_armed blocks a false vsync rise when reset releases in the middle of a frame
  assign vs_rise   = per_frame_vsync & ~vsync_d & vs_armed;
  assign vs_fall   = ~per_frame_vsync & vsync_d;
  assign href_rise = per_frame_href & ~href_d;
  assign href_fall = ~per_frame_href & href_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      vs_armed <= 1'b0;
    end else begin
      vsync_d  <= per_frame_vsync;
      href_d   <= per_frame_href;
      vs_armed <= vs_armed | ~per_frame_vsync;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      err_len <= 1'b0;
    end else if (vs_rise) begin
      state   <= ST_PRIME;
      col_cnt <= '0;
      row_cnt <= '0;
      err_len <= 1'b0;
    end else if (vs_fall) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_PRIME, ST_RUN: begin
          if (per_frame_href && per_frame_clken) col_cnt <= sat_inc10(col_cnt);
          if (href_fall) begin
            state <= ST_GAP;
            if (row_cnt != ROW_MAX) row_cnt <= row_cnt + 11'd1;
            if (col_cnt != COL_LEN) err_len <= 1'b1;
          end
        end
        ST_GAP: begin
          if (href_rise) begin
            state   <= (row_cnt < 11'(PRIME_LINES)) ? ST_PRIME : ST_RUN;
            // count restarts here, including the first pixel if it arrives on this edge
            col_cnt <= {9'd0, per_frame_clken};
          end
        end
        default: ;
      endcase
    end
  end

  // One cycle after a pixel, state/col_cnt/row_cnt describe that pixel (col_cnt = col+1).
  // The window centre sits one column behind the newest pixel, wrapping to the prior line's last column.
  assign run_pix  = (state == ST_RUN);
  assign ctr_col  = (col_cnt == 10'd1) ? COL_LAST : col_cnt - 10'd2;
  assign col_edge = (ctr_col == 10'd0) || (ctr_col == COL_LAST);
  assign row_edge = (row_cnt == 11'd2) || (row_cnt == ROW_MAX);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pix_d1     <= '0;
      vs_pipe    <= '0;
      href_pipe  <= '0;
      clken_pipe <= '0;
      win_valid  <= 1'b0;
      border     <= 1'b0;
    end else begin
      pix_d1     <= per_img_y;
      vs_pipe    <= {vs_pipe[PIPE_LAT-2:0], per_frame_vsync};
      href_pipe  <= {href_pipe[PIPE_LAT-2:0], per_frame_href};
      clken_pipe <= {clken_pipe[PIPE_LAT-2:0], per_frame_clken};
      win_valid  <= clken_pipe[0] & run_pix;
      border     <= clken_pipe[0] & run_pix & (col_edge | row_edge);
    end
  end

  assign post_frame_vsync = vs_pipe[PIPE_LAT-1];
  assign post_frame_href  = href_pipe[PIPE_LAT-1];
  assign post_frame_clken = clken_pipe[PIPE_LAT-1];

  win3x3_shift u_win (
    .clock   (clock),
    .rst_n   (rst_n),
    .en      (clken_pipe[0]),
    .col_top (lb_taps1x),
    .col_mid (lb_taps0x),
    .col_bot (pix_d1),
    .p11     (matrix_p11),
    .p12     (matrix_p12),
    .p13     (matrix_p13),
    .p21     (matrix_p21),
    .p22     (matrix_p22),
    .p23     (matrix_p23),
    .p31     (matrix_p31),
    .p32     (matrix_p32),
    .p33     (matrix_p33)
  );

endmodule

// File: tb/tb_line_win_ctrl.sv
// Directed bench for line_win_ctrl (IMG_W=8, IMG_H=4) with a behavioural two-tap line RAM.
module tb_line_win_ctrl;
  import vip_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  logic vsync = 1'b0, href = 1'b0, clken = 1'b0;
  logic [7:0] y = 8'd0;
  logic lb_clken, lb_href;
  logic [7:0] lb_shiftin, taps0, taps1;
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic post_vs, post_href, post_clken, win_valid, border, err_len;
  logic [9:0] col_cnt;
  logic [10:0] row_cnt;

  always #5 clock = ~clock;

  line_win_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .rst_n(rst_n),
    .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken), .per_img_y(y),
    .lb_clken(lb_clken), .lb_href(lb_href), .lb_shiftin(lb_shiftin),
    .lb_taps0x(taps0), .lb_taps1x(taps1),
    .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13),
    .matrix_p21(p21), .matrix_p22(p22), .matrix_p23(p23),
    .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
    .post_frame_vsync(post_vs), .post_frame_href(post_href), .post_frame_clken(post_clken),
    .win_valid(win_valid), .border(border),
    .col_cnt(col_cnt), .row_cnt(row_cnt), .err_len(err_len)
  );

  // Line RAM: taps are the same column one and two lines back, one cycle of read latency.
  logic [7:0] sr [0:2*W-1];
  always @(posedge clock) begin
    if (lb_clken && lb_href) begin
      for (int i = 2*W-1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= lb_shiftin;
      taps0 <= sr[W-1];
      taps1 <= sr[2*W-1];
    end
  end

  typedef struct packed { logic [71:0] pix; logic brd; } win_t;
  win_t wq[$];
  int wv_cnt = 0, pc_cnt = 0, brd_cnt = 0, lat_bad = 0, ok_cnt = 0;
  bit lat_en = 1'b0;
  logic [2:0] h1 = 3'd0, h2 = 3'd0;

  always @(negedge clock) begin
    h1 <= {vsync, href, clken};
    h2 <= h1;
    ok_cnt <= rst_n ? ok_cnt + 1 : 0;
    if (win_valid) wq.push_back({{p11, p12, p13, p21, p22, p23, p31, p32, p33}, border});
    wv_cnt  <= wv_cnt + (win_valid ? 1 : 0);
    pc_cnt  <= pc_cnt + (post_clken ? 1 : 0);
    brd_cnt <= brd_cnt + (border ? 1 : 0);
    if (lat_en && rst_n && ok_cnt >= 2 &&
        (({post_vs, post_href, post_clken} != h2) || (win_valid && !post_clken)))
      lat_bad <= lat_bad + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_line(input int row, input int npx, input bit gapped);
    href = 1'b1;
    for (int c = 0; c < npx; c++) begin
      if (gapped) begin clken = 1'b0; tick(); end
      clken = 1'b1; y = 8'(16*row + c); tick();
    end
    href = 1'b0; clken = 1'b0;
    tick(4);
  endtask

  task automatic frame_begin(); vsync = 1'b1; tick(2); endtask
  task automatic frame_end();   vsync = 1'b0; tick(3); endtask

  typedef struct { int idx; logic [71:0] pix; logic brd; } vec_t;
  vec_t tbl[9];

  task automatic check_windows(input int base, input string tag);
    for (int i = 0; i < 9; i++) begin
      if (base + tbl[i].idx < wq.size()) begin
        chk($sformatf("%s_win%0d_pix", tag, tbl[i].idx), wq[base + tbl[i].idx].pix, tbl[i].pix);
        chk($sformatf("%s_win%0d_border", tag, tbl[i].idx), wq[base + tbl[i].idx].brd, tbl[i].brd);
      end else begin
        chk($sformatf("%s_win%0d_count", tag, tbl[i].idx), wq.size() - base, tbl[i].idx + 1);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, wv0, pc0, b0;
    // index = window number in the frame: line 2 -> 0..7, line 3 -> 8..15 (newest column = index % 8)
    tbl[0] = '{2,  72'h00_01_02_10_11_12_20_21_22, 1'b1};
    tbl[1] = '{4,  72'h02_03_04_12_13_14_22_23_24, 1'b1};
    tbl[2] = '{7,  72'h05_06_07_15_16_17_25_26_27, 1'b1};
    tbl[3] = '{8,  72'h06_07_10_16_17_20_26_27_30, 1'b1};
    tbl[4] = '{9,  72'h07_10_11_17_20_21_27_30_31, 1'b1};
    tbl[5] = '{10, 72'h10_11_12_20_21_22_30_31_32, 1'b0};
    tbl[6] = '{12, 72'h12_13_14_22_23_24_32_33_34, 1'b0};
    tbl[7] = '{14, 72'h14_15_16_24_25_26_34_35_36, 1'b0};
    tbl[8] = '{15, 72'h15_16_17_25_26_27_35_36_37, 1'b0};

    // Reset
    #2 rst_n = 1'b0;
    #10;
    chk("reset_outs", {post_vs, post_href, post_clken, win_valid, border,
                       p11, p12, p13, p21, p22, p23, p31, p32, p33}, '0);
    chk("reset_cnts", {col_cnt, row_cnt, err_len}, '0);
    chk("reset_state", dut.state, ST_IDLE);
    @(posedge clock); #1;
    rst_n = 1'b1;
    tick(3);
    lat_en = 1'b1;

    // Full frame 4 x 8
    base = wq.size(); wv0 = wv_cnt; pc0 = pc_cnt; b0 = brd_cnt;
    frame_begin();
    chk("s1_state_prime", dut.state, ST_PRIME);
    send_line(0, W, 1'b0);
    send_line(1, W, 1'b0);
    chk("s1_prime_win_valid", wv_cnt - wv0, 0);
    chk("s1_prime_post_clken", pc_cnt - pc0, 16);
    chk("s1_row_after_prime", row_cnt, 2);
    chk("s1_col_after_line", col_cnt, W);
    send_line(2, W, 1'b0);
    send_line(3, W, 1'b0);
    chk("s1_win_valid_count", wv_cnt - wv0, 16);
    chk("s1_border_count", brd_cnt - b0, 10);
    chk("s1_row_final", row_cnt, H);
    chk("s1_err_len", err_len, 1'b0);
    check_windows(base, "s1");
    frame_end();
    chk("s1_state_idle", dut.state, ST_IDLE);

    // Short line 2, extra line for row saturation
    frame_begin();
    send_line(0, W, 1'b0);
    send_line(1, W, 1'b0);
    chk("s2_err_before", err_len, 1'b0);
    send_line(2, W-1, 1'b0);
    chk("s2_err_set", err_len, 1'b1);
    send_line(3, W, 1'b0);
    send_line(4, W, 1'b0);
    chk("s2_row_saturate", row_cnt, H);
    chk("s2_err_sticky", err_len, 1'b1);
    frame_end();
    chk("s2_err_after_vs_fall", err_len, 1'b1);
    vsync = 1'b1; tick();
    chk("s2_err_clear", err_len, 1'b0);
    chk("s2_state_prime", dut.state, ST_PRIME);

    // Same frame continues with line 3 clken gapped
    base = wq.size(); wv0 = wv_cnt; b0 = brd_cnt;
    tick();
    send_line(0, W, 1'b0);
    send_line(1, W, 1'b0);
    send_line(2, W, 1'b0);
    send_line(3, W, 1'b1);
    chk("s3_win_valid_count", wv_cnt - wv0, 16);
    chk("s3_border_count", brd_cnt - b0, 10);
    check_windows(base, "s3");
    frame_end();

    // Reset pulse at line 2 col 4
    frame_begin();
    send_line(0, W, 1'b0);
    send_line(1, W, 1'b0);
    href = 1'b1;
    for (int c = 0; c < 4; c++) begin clken = 1'b1; y = 8'(32 + c); tick(); end
    y = 8'h24;
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_outs", {post_vs, post_href, post_clken, win_valid, border,
                        p11, p12, p13, p21, p22, p23, p31, p32, p33}, '0);
    chk("s4_rst_cnts", {col_cnt, row_cnt, err_len}, '0);
    chk("s4_rst_state", dut.state, ST_IDLE);
    @(posedge clock); #1;
    rst_n = 1'b1;
    wv0 = wv_cnt;
    for (int c = 5; c < W; c++) begin clken = 1'b1; y = 8'(32 + c); tick(); end
    href = 1'b0; clken = 1'b0; tick(4);
    send_line(3, W, 1'b0);
    chk("s4_no_win_valid", wv_cnt - wv0, 0);
    chk("s4_state_idle", dut.state, ST_IDLE);
    frame_end();
    frame_begin();
    chk("s4_state_prime", dut.state, ST_PRIME);

    // vsync restarts mid-line 3
    send_line(0, W, 1'b0);
    send_line(1, W, 1'b0);
    send_line(2, W, 1'b0);
    chk("s5_row_before", row_cnt, 3);
    href = 1'b1;
    for (int c = 0; c < 4; c++) begin clken = 1'b1; y = 8'(48 + c); tick(); end
    clken = 1'b0; vsync = 1'b0; tick();
    vsync = 1'b1; tick();
    chk("s5_state_prime", dut.state, ST_PRIME);
    chk("s5_row_zero", row_cnt, 0);
    chk("s5_col_zero", col_cnt, 0);
    href = 1'b0; tick(4);
    frame_end();

    chk("post_delay2_and_valid_gating", lat_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
